// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: ID->EX pipeline register with valid/ready handshake and a
// one-entry skid buffer. in_ready depends only on registered state, never on
// out_ready, so the stage breaks the combinational ready path back into decode.
// Optional feature macro: ID_EX_STALL_CNT_EN (adds a saturating stall counter).
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | nothing held, out_valid=0, in_ready=1
// FULL  | main register live, skid empty
// SKID  | main and skid live, in_ready=0
module id_ex_skid_stage #(
   parameter int DATA_W = 71,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   // Encoding chosen so bit 0 is out_valid and bit 1 is skid_valid directly.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_pop;
   logic              w_accept;
   logic              w_ld_main_in;
   logic              w_ld_main_skid;
   logic              w_ld_skid;

   assign out_valid = r_state[0];
   assign in_ready  = ~r_state[1];
   assign out_data  = r_out_data;
   assign w_pop     = r_state[0] & out_ready;
   assign w_accept  = in_valid & ~r_state[1];

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and register load enables; flush overrides every transition.
   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_state_nxt  = FULL;
                  w_ld_main_in = 1'b1;
               end
            end
            FULL: begin
               if (w_pop && w_accept) begin
                  w_ld_main_in = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = EMPTY;
               end else if (w_accept) begin
                  w_state_nxt = SKID;
                  w_ld_skid   = 1'b1;
               end
            end
            SKID: begin
               if (w_pop) begin
                  w_state_nxt    = FULL;
                  w_ld_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   // Data registers; they keep their last value when not loaded.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_out_data <= in_data;
         end else if (w_ld_main_skid) begin
            r_out_data <= r_skid_data;
         end
         if (w_ld_skid) begin
            r_skid_data <= in_data;
         end
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   assign stall_cnt = r_stall_cnt;

   // Saturating count of back-pressured cycles; only reset clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cnt <= '0;
      end else if (r_state[0] && !out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end
`else
   // Counter width is only meaningful when the counter is built.
   logic w_unused_cnt_w;
   assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
